rom_stream_reader: RTL and testbench

- Reader-side sequencer for the team's single-port inferred weight ROM. The ROM has 1-cycle registered read latency and takes an address with no handshake.
- On a start pulse, the block walks a programmable window of ROM addresses and turns the returned words into a ready/valid stream with a last flag.
- It sits between each layer's weight ROM and the layer MAC datapath. A 3-entry buffer absorbs backpressure without losing in-flight ROM reads.

---
 rtl/rom_stream_reader.sv | 139 +++++++++++++
 tb/tb_rom_stream_reader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_reader.sv
// Walks a window of weight-ROM addresses and turns the 1-cycle-latency read data
// into a ready/valid stream with a last flag, buffered three deep against backpressure.
module rom_stream_reader #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned WORD_SIZE  = 8,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned LENGTH     = 2**ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [WORD_SIZE-1:0]  rom_data_i,
  output logic [WORD_SIZE-1:0]  data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         LEN      = CW'(LENGTH);
  localparam logic [CW-1:0]         LAST_IDX = CW'(LENGTH - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_e;

  state_e                state_q;
  logic                  busy_q, done_q, inflight_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0]         issued_q, accepted_q;

  logic [WORD_SIZE-1:0]  buf_q [3];
  logic [1:0]            rd_ptr_q, wr_ptr_q, cnt_q, cnt_d;

  logic                  issue, push, pop, final_hs;
  logic [2:0]            occ;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Occupancy counts the word already in flight so the buffer can never overflow;
  // only registered terms feed issue, keeping ready_i off the address path.
  assign occ      = {1'b0, cnt_q} + {2'b00, inflight_q};
  assign issue    = (state_q == STREAM) && (issued_q < LEN) && (occ < 3'd3);
  assign push     = inflight_q;
  assign valid_o  = (cnt_q != 2'd0);
  assign pop      = valid_o & ready_i;
  assign final_hs = (state_q == STREAM) && pop && (accepted_q == LAST_IDX);
  assign last_o   = valid_o && (accepted_q == LAST_IDX);

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign rom_addr_o = addr_q;

  always_comb begin
    data_o = buf_q[0];
    case (rd_ptr_q)
      2'd1:    data_o = buf_q[1];
      2'd2:    data_o = buf_q[2];
      default: data_o = buf_q[0];
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      addr_q     <= BASE;
      issued_q   <= '0;
      accepted_q <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        addr_q   <= addr_q + ADDR_WIDTH'(1);
        issued_q <= issued_q + CW'(1);
      end
      if (pop) accepted_q <= accepted_q + CW'(1);
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q    <= STREAM;
            busy_q     <= 1'b1;
            addr_q     <= BASE;
            issued_q   <= '0;
            accepted_q <= '0;
          end
        end
        STREAM: begin
          if (final_hs) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 3; i++) buf_q[i] <= '0;
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        buf_q[wr_ptr_q] <= rom_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench: three reader configurations (full window, wrapped window, single word),
// each fed by a ROM model returning addr+0x10 one cycle after the address.
module tb_rom_stream_reader;

  logic clk, rst;
  int   n_chk, n_fail;

  logic       start0, ready0, busy0, done0, valid0, last0;
  logic [2:0] addr0;
  logic [7:0] rdata0, data0;
  logic       start1, ready1, busy1, done1, valid1, last1;
  logic [2:0] addr1;
  logic [7:0] rdata1, data1;
  logic       start2, ready2, busy2, done2, valid2, last2;
  logic [2:0] addr2;
  logic [7:0] rdata2, data2;

  rom_stream_reader #(.ADDR_WIDTH(3), .WORD_SIZE(8), .BASE_ADDR(0), .LENGTH(8)) u0 (
    .clk_i(clk), .reset_i(rst), .start_i(start0), .busy_o(busy0), .done_o(done0),
    .rom_addr_o(addr0), .rom_data_i(rdata0), .data_o(data0), .valid_o(valid0),
    .ready_i(ready0), .last_o(last0));

  rom_stream_reader #(.ADDR_WIDTH(3), .WORD_SIZE(8), .BASE_ADDR(6), .LENGTH(4)) u1 (
    .clk_i(clk), .reset_i(rst), .start_i(start1), .busy_o(busy1), .done_o(done1),
    .rom_addr_o(addr1), .rom_data_i(rdata1), .data_o(data1), .valid_o(valid1),
    .ready_i(ready1), .last_o(last1));

  rom_stream_reader #(.ADDR_WIDTH(3), .WORD_SIZE(8), .BASE_ADDR(0), .LENGTH(1)) u2 (
    .clk_i(clk), .reset_i(rst), .start_i(start2), .busy_o(busy2), .done_o(done2),
    .rom_addr_o(addr2), .rom_data_i(rdata2), .data_o(data2), .valid_o(valid2),
    .ready_i(ready2), .last_o(last2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    rdata0 <= {5'b0, addr0} + 8'h10;
    rdata1 <= {5'b0, addr1} + 8'h10;
    rdata2 <= {5'b0, addr2} + 8'h10;
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++; if (busy0 !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    n_chk++; if (done0 !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b expected 0", done0); end
    n_chk++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid0); end
    n_chk++; if (last0 !== 1'b0)  begin n_fail++; $display("FAIL reset_last: got %b expected 0", last0); end
    n_chk++; if (data0 !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data0); end
    n_chk++; if (addr0 !== 3'd0)  begin n_fail++; $display("FAIL reset_addr0: got %0d expected 0", addr0); end
    n_chk++; if (addr1 !== 3'd6)  begin n_fail++; $display("FAIL reset_addr1: got %0d expected 6", addr1); end
    rst = 1'b0;
  endtask

  // Uninterrupted 8-word pass; word k is presented at cycle 2+k after the start edge.
  task automatic test_basic();
    logic ev;
    @(negedge clk); ready0 = 1'b1; start0 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      ev = (c >= 2 && c <= 9);
      n_chk++; if (valid0 !== ev) begin n_fail++; $display("FAIL basic_valid c=%0d: got %b expected %b", c, valid0, ev); end
      if (ev) begin
        n_chk++; if (data0 !== 8'(16 + c - 2)) begin n_fail++; $display("FAIL basic_data c=%0d: got %h expected %h", c, data0, 8'(16 + c - 2)); end
      end
      n_chk++; if (last0 !== (c == 9))  begin n_fail++; $display("FAIL basic_last c=%0d: got %b", c, last0); end
      n_chk++; if (done0 !== (c == 10)) begin n_fail++; $display("FAIL basic_done c=%0d: got %b", c, done0); end
      n_chk++; if (busy0 !== (c <= 9))  begin n_fail++; $display("FAIL basic_busy c=%0d: got %b", c, busy0); end
    end
  endtask

  task automatic test_backpressure();
    int got, dones;
    got = 0; dones = 0;
    @(negedge clk); ready0 = 1'b1; start0 = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      ready0 = !(c >= 5 && c <= 9);
      if (c >= 5 && c <= 9) begin
        n_chk++; if (valid0 !== 1'b1 || data0 !== 8'h13) begin n_fail++; $display("FAIL bp_hold c=%0d: got v=%b d=%h expected v=1 d=13", c, valid0, data0); end
      end
      if (valid0 && ready0) begin
        n_chk++; if (data0 !== 8'(16 + got)) begin n_fail++; $display("FAIL bp_data #%0d: got %h expected %h", got, data0, 8'(16 + got)); end
        n_chk++; if (last0 !== (got == 7))   begin n_fail++; $display("FAIL bp_last #%0d: got %b", got, last0); end
        got++;
      end
      if (done0) dones++;
    end
    n_chk++; if (got != 8)       begin n_fail++; $display("FAIL bp_count: got %0d words expected 8", got); end
    n_chk++; if (dones != 1)     begin n_fail++; $display("FAIL bp_done: got %0d pulses expected 1", dones); end
    n_chk++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL bp_busy_end: got %b expected 0", busy0); end
  endtask

  // Two passes of BASE=6 LENGTH=4; the second proves the address reload on start.
  task automatic test_wrap();
    logic ev;
    for (int p = 0; p < 2; p++) begin
      @(negedge clk); ready1 = 1'b1; start1 = 1'b1;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        start1 = 1'b0;
        ev = (c >= 2 && c <= 5);
        n_chk++; if (addr1 !== 3'((6 + ((c < 4) ? c : 4)) % 8)) begin n_fail++; $display("FAIL wrap_addr p=%0d c=%0d: got %0d", p, c, addr1); end
        n_chk++; if (valid1 !== ev) begin n_fail++; $display("FAIL wrap_valid p=%0d c=%0d: got %b expected %b", p, c, valid1, ev); end
        if (ev) begin
          n_chk++; if (data1 !== 8'(16 + ((6 + c - 2) % 8))) begin n_fail++; $display("FAIL wrap_data p=%0d c=%0d: got %h expected %h", p, c, data1, 8'(16 + ((6 + c - 2) % 8))); end
        end
        n_chk++; if (last1 !== (c == 5)) begin n_fail++; $display("FAIL wrap_last p=%0d c=%0d: got %b", p, c, last1); end
        n_chk++; if (done1 !== (c == 6)) begin n_fail++; $display("FAIL wrap_done p=%0d c=%0d: got %b", p, c, done1); end
      end
    end
  endtask

  // Extra starts mid-pass and during DONE are ignored; the one after DONE begins pass two.
  task automatic test_restart();
    int d;
    logic ev;
    @(negedge clk); ready0 = 1'b1; start0 = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      start0 = (c == 4 || c == 10 || c == 11);
      d = (c < 12) ? c : c - 12;
      ev = (d >= 2 && d <= 9);
      n_chk++; if (valid0 !== ev) begin n_fail++; $display("FAIL restart_valid c=%0d: got %b expected %b", c, valid0, ev); end
      if (ev) begin
        n_chk++; if (data0 !== 8'(16 + d - 2)) begin n_fail++; $display("FAIL restart_data c=%0d: got %h expected %h", c, data0, 8'(16 + d - 2)); end
      end
      n_chk++; if (done0 !== (d == 10)) begin n_fail++; $display("FAIL restart_done c=%0d: got %b", c, done0); end
      n_chk++; if (busy0 !== (d <= 9))  begin n_fail++; $display("FAIL restart_busy c=%0d: got %b", c, busy0); end
    end
    start0 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic ev;
    @(negedge clk); ready0 = 1'b0; start0 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    n_chk++; if (valid0 !== 1'b1 || data0 !== 8'h10) begin n_fail++; $display("FAIL rmid_pre: got v=%b d=%h expected v=1 d=10", valid0, data0); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", valid0); end
    n_chk++; if (busy0 !== 1'b0)  begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy0); end
    n_chk++; if (data0 !== 8'h00) begin n_fail++; $display("FAIL rmid_data: got %h expected 00", data0); end
    n_chk++; if (addr0 !== 3'd0)  begin n_fail++; $display("FAIL rmid_addr: got %0d expected 0", addr0); end
    @(negedge clk);
    rst = 1'b0;
    ready0 = 1'b1;
    @(negedge clk);
    n_chk++; if (valid0 !== 1'b0 || done0 !== 1'b0) begin n_fail++; $display("FAIL rmid_after: got v=%b done=%b expected 0 0", valid0, done0); end
    start0 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      ev = (c >= 2 && c <= 9);
      n_chk++; if (valid0 !== ev) begin n_fail++; $display("FAIL rmid_pass_valid c=%0d: got %b expected %b", c, valid0, ev); end
      if (ev) begin
        n_chk++; if (data0 !== 8'(16 + c - 2)) begin n_fail++; $display("FAIL rmid_pass_data c=%0d: got %h expected %h", c, data0, 8'(16 + c - 2)); end
      end
      n_chk++; if (done0 !== (c == 10)) begin n_fail++; $display("FAIL rmid_pass_done c=%0d: got %b", c, done0); end
    end
  endtask

  task automatic test_len1();
    logic ev;
    @(negedge clk); ready2 = 1'b0; start2 = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      ready2 = (c == 1 || c == 4);
      ev = (c >= 2 && c <= 4);
      n_chk++; if (valid2 !== ev) begin n_fail++; $display("FAIL len1_valid c=%0d: got %b expected %b", c, valid2, ev); end
      if (ev) begin
        n_chk++; if (data2 !== 8'h10 || last2 !== 1'b1) begin n_fail++; $display("FAIL len1_word c=%0d: got d=%h last=%b expected d=10 last=1", c, data2, last2); end
      end
      n_chk++; if (addr2 !== ((c == 0) ? 3'd0 : 3'd1)) begin n_fail++; $display("FAIL len1_addr c=%0d: got %0d", c, addr2); end
      n_chk++; if (done2 !== (c == 5)) begin n_fail++; $display("FAIL len1_done c=%0d: got %b", c, done2); end
      n_chk++; if (busy2 !== (c <= 4)) begin n_fail++; $display("FAIL len1_busy c=%0d: got %b", c, busy2); end
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1;
    start0 = 1'b0; ready0 = 1'b0;
    start1 = 1'b0; ready1 = 1'b0;
    start2 = 1'b0; ready2 = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_restart();
    test_reset_mid();
    test_len1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
